// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage slot controller.
// Defines the slot states and the memory-access opcodes it needs to recognise.
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        StEmpty   = 2'b00,
        StFull    = 2'b01,
        StMemWait = 2'b10,
        StBubble  = 2'b11
    } ex_state_e;

    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OpcLoad) || (opcode == OpcStore);
    endfunction

endpackage

// File: rtl/ex_ctrl_hazard_detect.sv
// Load-use comparator: flags a decode instruction reading the register a load in EX will write.
// Purely combinational; the caller qualifies it with EX occupancy.
module ex_ctrl_hazard_detect (
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_num_i,
    input  logic [4:0] rs1_num_i,
    input  logic [4:0] rs2_num_i,
    output logic       hazard_o
);

    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign hazard_o = ex_is_load_i && (ex_rd_num_i != 5'd0) &&
                      ((ex_rd_num_i == rs1_num_i) || (ex_rd_num_i == rs2_num_i));

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage slot controller: drives the ID/EX capture enable, handles load-use bubbles,
// memory back-pressure and deferred flushes, and counts decode stall cycles.
module ex_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [6:0]             i_id_opcode,
    input  logic [4:0]             i_id_rs1_num,
    input  logic [4:0]             i_id_rs2_num,
    input  logic [4:0]             i_id_rd_num,
    input  logic                   i_mem_ready,
    input  logic                   i_flush,
    output logic                   o_ex_load,
    output logic                   o_ex_valid,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    ex_state_e              state_q, state_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   ex_is_load_q, ex_is_load_d;
    logic                   ex_is_mem_q, ex_is_mem_d;
    logic [4:0]             ex_rd_num_q, ex_rd_num_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_ex;
    logic hold;
    logic retire;
    logic hazard_raw;
    logic hazard;
    logic id_ready;
    logic ex_load;

    ex_ctrl_hazard_detect u_hazard_detect (
        .ex_is_load_i (ex_is_load_q),
        .ex_rd_num_i  (ex_rd_num_q),
        .rs1_num_i    (i_id_rs1_num),
        .rs2_num_i    (i_id_rs2_num),
        .hazard_o     (hazard_raw)
    );

    always_comb begin
        in_ex    = (state_q == StFull) || (state_q == StMemWait);
        hold     = in_ex && ex_is_mem_q && !i_mem_ready;
        retire   = in_ex && !hold;
        // EX registers keep stale contents once empty, so only trust them while occupied.
        hazard   = in_ex && hazard_raw;
        id_ready = !hold && !hazard && !i_flush && !flush_pend_q;
        ex_load  = i_id_valid && id_ready;
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        ex_is_load_d = ex_is_load_q;
        ex_is_mem_d  = ex_is_mem_q;
        ex_rd_num_d  = ex_rd_num_q;
        stall_cnt_d  = stall_cnt_q;

        if (ex_load) begin
            ex_is_load_d = (i_id_opcode == OpcLoad);
            ex_is_mem_d  = is_mem_op(i_id_opcode);
            ex_rd_num_d  = i_id_rd_num;
        end

        // A redirect arriving while EX is frozen must still kill the instruction behind it.
        if (hold && i_flush) begin
            flush_pend_d = 1'b1;
        end else if (retire || ex_load) begin
            flush_pend_d = 1'b0;
        end

        unique case (state_q)
            StEmpty, StBubble: begin
                state_d = ex_load ? StFull : StEmpty;
            end
            StFull, StMemWait: begin
                if (hold) begin
                    state_d = StMemWait;
                end else if (i_flush || flush_pend_q) begin
                    state_d = StEmpty;
                end else if (hazard && i_id_valid) begin
                    state_d = StBubble;
                end else if (ex_load) begin
                    state_d = StFull;
                end else begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (i_id_valid && !id_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StEmpty;
            flush_pend_q <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_is_mem_q  <= 1'b0;
            ex_rd_num_q  <= 5'd0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            ex_is_load_q <= ex_is_load_d;
            ex_is_mem_q  <= ex_is_mem_d;
            ex_rd_num_q  <= ex_rd_num_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_id_ready  = id_ready;
    assign o_ex_load   = ex_load;
    assign o_ex_valid  = in_ex;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_ctrl.sv
// Directed bench for ex_ctrl: throughput, load-use bubble, x0/store exemptions,
// flush during memory wait, reset mid-wait and counter saturation on a narrow instance.
module tb_ex_ctrl;
    import ex_ctrl_pkg::*;

    localparam logic [6:0] OpAddi = 7'h13;
    localparam logic [6:0] OpAdd  = 7'h33;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        mem_ready;
    logic        flush;
    logic        id_ready, ex_load, ex_valid;
    logic [15:0] stall_cnt;
    logic        id_ready4, ex_load4, ex_valid4;
    logic [3:0]  stall_cnt4;

    int checks;
    int failures;

    ex_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_id_valid   (id_valid),
        .o_id_ready   (id_ready),
        .i_id_opcode  (id_opcode),
        .i_id_rs1_num (id_rs1),
        .i_id_rs2_num (id_rs2),
        .i_id_rd_num  (id_rd),
        .i_mem_ready  (mem_ready),
        .i_flush      (flush),
        .o_ex_load    (ex_load),
        .o_ex_valid   (ex_valid),
        .o_stall_cnt  (stall_cnt)
    );

    ex_ctrl #(.STALL_CNT_W(4)) dut4 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_id_valid   (id_valid),
        .o_id_ready   (id_ready4),
        .i_id_opcode  (id_opcode),
        .i_id_rs1_num (id_rs1),
        .i_id_rs2_num (id_rs2),
        .i_id_rd_num  (id_rd),
        .i_mem_ready  (mem_ready),
        .i_flush      (flush),
        .o_ex_load    (ex_load4),
        .o_ex_valid   (ex_valid4),
        .o_stall_cnt  (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        flush     = 1'b0;
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_id_ready", 32'(id_ready), 32'd1);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(StEmpty));

        // Four independent ADDIs stream through at one per cycle.
        for (int k = 0; k < 4; k++) begin
            present(1'b1, OpAddi, 5'd0, 5'd0, 5'(k + 1));
            #1;
            chk("stream_ex_load", 32'(ex_load), 32'd1);
            tick();
            chk("stream_ex_valid", 32'(ex_valid), 32'd1);
        end
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        tick();
        chk("stream_drain", 32'(ex_valid), 32'd0);
        chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // LOAD x5 followed by a dependent ADD: one bubble.
        present(1'b1, OpcLoad, 5'd2, 5'd0, 5'd5);
        tick();
        present(1'b1, OpAdd, 5'd5, 5'd1, 5'd6);
        #1;
        chk("luse_id_ready", 32'(id_ready), 32'd0);
        chk("luse_ex_load", 32'(ex_load), 32'd0);
        tick();
        chk("luse_bubble_state", 32'(dut.state_q), 32'(StBubble));
        chk("luse_bubble_valid", 32'(ex_valid), 32'd0);
        chk("luse_accept", 32'(ex_load), 32'd1);
        tick();
        chk("luse_full", 32'(dut.state_q), 32'(StFull));
        chk("luse_stall_cnt", 32'(stall_cnt), 32'd1);
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        tick();

        // LOAD x0 never causes a load-use stall.
        present(1'b1, OpcLoad, 5'd3, 5'd0, 5'd0);
        tick();
        present(1'b1, OpAdd, 5'd0, 5'd0, 5'd6);
        #1;
        chk("x0_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("x0_no_bubble", 32'(dut.state_q), 32'(StFull));
        chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);

        // A STORE whose rd field matches a source is not a hazard.
        present(1'b1, OpcStore, 5'd1, 5'd2, 5'd7);
        tick();
        present(1'b1, OpAdd, 5'd7, 5'd0, 5'd8);
        #1;
        chk("store_no_hazard", 32'(id_ready), 32'd1);
        tick();
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        tick();
        chk("store_drain", 32'(dut.state_q), 32'(StEmpty));

        // Fresh counter, then flush during a 3-cycle memory wait.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        present(1'b1, OpcStore, 5'd1, 5'd2, 5'd0);
        tick();
        present(1'b1, OpAddi, 5'd0, 5'd0, 5'd9);
        mem_ready = 1'b0;
        #1;
        chk("mw_c1_id_ready", 32'(id_ready), 32'd0);
        chk("mw_c1_ex_load", 32'(ex_load), 32'd0);
        tick();
        flush = 1'b1;
        #1;
        chk("mw_c2_state", 32'(dut.state_q), 32'(StMemWait));
        chk("mw_c2_id_ready", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("mw_c3_state", 32'(dut.state_q), 32'(StMemWait));
        chk("mw_c3_ex_load", 32'(ex_load), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("mw_c4_state", 32'(dut.state_q), 32'(StMemWait));
        chk("mw_c4_id_ready", 32'(id_ready), 32'd0);
        chk("mw_c4_ex_load", 32'(ex_load), 32'd0);
        tick();
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        #1;
        chk("mw_after_state", 32'(dut.state_q), 32'(StEmpty));
        chk("mw_after_valid", 32'(ex_valid), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        tick();

        // Reset during MEM_WAIT abandons the held store.
        present(1'b1, OpcStore, 5'd1, 5'd2, 5'd0);
        tick();
        present(1'b1, OpAddi, 5'd0, 5'd0, 5'd9);
        mem_ready = 1'b0;
        tick();
        chk("rst_mw_state", 32'(dut.state_q), 32'(StMemWait));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rst_mw_after_state", 32'(dut.state_q), 32'(StEmpty));
        chk("rst_mw_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_mw_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mw_id_ready", 32'(id_ready), 32'd1);

        // 20 stall cycles: the 4-bit instance must stick at 15.
        present(1'b1, OpcStore, 5'd1, 5'd2, 5'd0);
        tick();
        present(1'b1, OpAddi, 5'd0, 5'd0, 5'd9);
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_wide_cnt", 32'(stall_cnt), 32'd20);
        chk("sat_narrow_cnt", 32'(stall_cnt4), 32'd15);
        chk("sat_narrow_valid", 32'(ex_valid4), 32'd1);
        chk("sat_narrow_ready", 32'(id_ready4), 32'd0);
        chk("sat_narrow_load", 32'(ex_load4), 32'd0);
        mem_ready = 1'b1;
        present(1'b0, OpAddi, 5'd0, 5'd0, 5'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
